crc_stream_engine: RTL and testbench

//  Multi-byte-per-cycle CRC engine for framed streams: folds DATA_WIDTH/8 bytes per accepted beat

---
 rtl/crc_stream_engine.sv | 123 ++++++++++++
 tb/tb_crc_stream_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: folds up to DATA_WIDTH/8 bytes per accepted beat into an LFSR CRC,
// then presents the transformed result with an expected-value compare and a keep-error flag.
module crc_stream_engine #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [31:0]          CRC_POLY   = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT   = '1,
    parameter bit                   REFIN      = 1'b1,
    parameter bit                   REFOUT     = 1'b1,
    parameter logic [CRC_WIDTH-1:0] XOROUT     = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH/8-1:0] s_keep,
    input  logic                    s_last,
    input  logic [CRC_WIDTH-1:0]    s_exp,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CRC_WIDTH-1:0]    m_crc,
    output logic                    m_match,
    output logic                    m_err
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [CRC_WIDTH-1:0] POLY = CRC_POLY[CRC_WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CRC_WIDTH-1:0]   crc_reg;
    logic                   err_reg;

    logic                   beat;
    logic [CRC_WIDTH-1:0]   crc_beat;
    logic [CRC_WIDTH-1:0]   crc_rev;
    logic [CRC_WIDTH-1:0]   crc_out;
    logic [NB-1:0]          keep_inc;
    logic                   keep_gap;
    logic                   keep_short;
    logic                   keep_viol;

    // Eight serial LFSR steps for one byte, unrolled; REFIN selects LSB- or MSB-first feed.
    function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] crc_in,
                                                      input logic [7:0]           data);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[CRC_WIDTH-1] ^ (REFIN ? data[b] : data[7-b]);
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    assign m_valid = (state_reg == DONE);
    assign s_ready = !m_valid || m_ready;
    assign beat    = s_valid && s_ready;

    // Lanes fold in stream order; disabled lanes pass the register through untouched.
    always_comb begin
        crc_beat = crc_reg;
        for (int i = 0; i < NB; i++) begin
            if (s_keep[i]) begin
                crc_beat = crc_byte(crc_beat, s_data[8*i +: 8]);
            end
        end
    end

    for (genvar gi = 0; gi < CRC_WIDTH; gi++) begin : g_rev
        assign crc_rev[gi] = crc_beat[CRC_WIDTH-1-gi];
    end

    assign crc_out = (REFOUT ? crc_rev : crc_beat) ^ XOROUT;

    // Contiguous-from-lane-0 keep has no set bit that survives keep & (keep + 1).
    assign keep_inc   = s_keep + NB'(1);
    assign keep_gap   = |(s_keep & keep_inc);
    assign keep_short = !(&s_keep) && !s_last;
    assign keep_viol  = keep_gap || keep_short;

    always_comb begin
        state_next = state_reg;
        if (beat) begin
            state_next = s_last ? DONE : BUSY;
        end else if (state_reg == DONE && m_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            crc_reg   <= CRC_INIT;
            err_reg   <= 1'b0;
            m_crc     <= '0;
            m_match   <= 1'b0;
            m_err     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (beat) begin
                if (s_last) begin
                    crc_reg <= CRC_INIT;
                    err_reg <= 1'b0;
                    m_crc   <= crc_out;
                    m_match <= (crc_out == s_exp);
                    m_err   <= err_reg || keep_viol;
                end else begin
                    crc_reg <= crc_beat;
                    err_reg <= err_reg || keep_viol;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: CRC-32/DW32, CRC-16/DW32, CRC-16/DW8 and CRC-8/DW8 instances
// driven with directed vectors; monitors pop expected results whenever a result is handed over.
module tb_crc_stream_engine;

    typedef struct packed {
        logic [31:0] crc;
        logic        match;
        logic        err;
        logic        chk;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;

    // 32-bit stream bus shared by the CRC-32 and CRC-16 wide instances
    logic [31:0] d32;
    logic [3:0]  k32;
    logic        l32;
    logic        v_c32, v_c16w;
    logic        r_c32, r_c16w;
    logic [31:0] e32;
    logic [15:0] e16w;
    logic        sr_c32, mv_c32, mt_c32, er_c32;
    logic [31:0] crc_c32;
    logic        sr_c16w, mv_c16w, mt_c16w, er_c16w;
    logic [15:0] crc_c16w;

    // 8-bit stream bus shared by the CRC-8 and CRC-16 narrow instances
    logic [7:0]  d8;
    logic [0:0]  k8;
    logic        l8;
    logic        v_c8, v_c16n;
    logic        r_c8, r_c16n;
    logic [7:0]  e8;
    logic [15:0] e16n;
    logic        sr_c8, mv_c8, mt_c8, er_c8;
    logic [7:0]  crc_c8;
    logic        sr_c16n, mv_c16n, mt_c16n, er_c16n;
    logic [15:0] crc_c16n;

    exp_t sb_c32[$];
    exp_t sb_c16w[$];
    exp_t sb_c8[$];
    exp_t sb_c16n[$];

    crc_stream_engine #(.DATA_WIDTH(32)) u_c32 (
        .clk(clk), .rst(rst), .s_valid(v_c32), .s_ready(sr_c32), .s_data(d32), .s_keep(k32),
        .s_last(l32), .s_exp(e32), .m_valid(mv_c32), .m_ready(r_c32), .m_crc(crc_c32),
        .m_match(mt_c32), .m_err(er_c32)
    );

    crc_stream_engine #(
        .DATA_WIDTH(32), .CRC_WIDTH(16), .CRC_POLY(32'h0000_1021), .CRC_INIT(16'hFFFF),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
    ) u_c16w (
        .clk(clk), .rst(rst), .s_valid(v_c16w), .s_ready(sr_c16w), .s_data(d32), .s_keep(k32),
        .s_last(l32), .s_exp(e16w), .m_valid(mv_c16w), .m_ready(r_c16w), .m_crc(crc_c16w),
        .m_match(mt_c16w), .m_err(er_c16w)
    );

    crc_stream_engine #(
        .DATA_WIDTH(8), .CRC_WIDTH(16), .CRC_POLY(32'h0000_1021), .CRC_INIT(16'hFFFF),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
    ) u_c16n (
        .clk(clk), .rst(rst), .s_valid(v_c16n), .s_ready(sr_c16n), .s_data(d8), .s_keep(k8),
        .s_last(l8), .s_exp(e16n), .m_valid(mv_c16n), .m_ready(r_c16n), .m_crc(crc_c16n),
        .m_match(mt_c16n), .m_err(er_c16n)
    );

    crc_stream_engine #(
        .DATA_WIDTH(8), .CRC_WIDTH(8), .CRC_POLY(32'h0000_0007), .CRC_INIT(8'h00),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(8'h00)
    ) u_c8 (
        .clk(clk), .rst(rst), .s_valid(v_c8), .s_ready(sr_c8), .s_data(d8), .s_keep(k8),
        .s_last(l8), .s_exp(e8), .m_valid(mv_c8), .m_ready(r_c8), .m_crc(crc_c8),
        .m_match(mt_c8), .m_err(er_c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] c, input logic m, input logic er, input logic chk);
        exp_t e;
        e.crc   = c;
        e.match = m;
        e.err   = er;
        e.chk   = chk;
        return e;
    endfunction

    task automatic score(input string nm, input bit have, input exp_t e,
                         input logic [31:0] c, input logic m, input logic er);
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: unexpected result crc=%08h match=%0b err=%0b", nm, c, m, er);
        end else if (er !== e.err || (e.chk && (c !== e.crc || m !== e.match))) begin
            n_fail++;
            $display("FAIL %s: got crc=%08h match=%0b err=%0b, required crc=%08h match=%0b err=%0b (crc checked=%0b)",
                     nm, c, m, er, e.crc, e.match, e.err, e.chk);
        end else begin
            $display("ok   %s: crc=%08h match=%0b err=%0b", nm, c, m, er);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", nm, act, req);
        end else begin
            $display("ok   %s: %08h", nm, act);
        end
    endtask

    always @(negedge clk) begin : mon_c32
        exp_t e;
        bit   have;
        if (!rst && mv_c32 && r_c32) begin
            have = (sb_c32.size() != 0);
            e    = '0;
            if (have) e = sb_c32.pop_front();
            score("crc32", have, e, crc_c32, mt_c32, er_c32);
        end
    end

    always @(negedge clk) begin : mon_c16w
        exp_t e;
        bit   have;
        if (!rst && mv_c16w && r_c16w) begin
            have = (sb_c16w.size() != 0);
            e    = '0;
            if (have) e = sb_c16w.pop_front();
            score("crc16_dw32", have, e, {16'h0, crc_c16w}, mt_c16w, er_c16w);
        end
    end

    always @(negedge clk) begin : mon_c16n
        exp_t e;
        bit   have;
        if (!rst && mv_c16n && r_c16n) begin
            have = (sb_c16n.size() != 0);
            e    = '0;
            if (have) e = sb_c16n.pop_front();
            score("crc16_dw8", have, e, {16'h0, crc_c16n}, mt_c16n, er_c16n);
        end
    end

    always @(negedge clk) begin : mon_c8
        exp_t e;
        bit   have;
        if (!rst && mv_c8 && r_c8) begin
            have = (sb_c8.size() != 0);
            e    = '0;
            if (have) e = sb_c8.pop_front();
            score("crc8", have, e, {24'h0, crc_c8}, mt_c8, er_c8);
        end
    end

    // One beat on the 32-bit bus; sel=0 targets the CRC-32 instance, sel=1 the CRC-16 one.
    task automatic send32(input bit sel, input logic [31:0] data, input logic [3:0] keep, input logic last);
        logic rdy;
        d32 = data;
        k32 = keep;
        l32 = last;
        if (sel) v_c16w = 1'b1;
        else     v_c32  = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 40 && !rdy; i++) begin
            @(negedge clk);
            rdy = sel ? sr_c16w : sr_c32;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL send32: s_ready stayed low for 40 cycles");
        end
        @(posedge clk);
        #1;
        v_c32  = 1'b0;
        v_c16w = 1'b0;
        d32    = $urandom;
        k32    = 4'($urandom);
        l32    = 1'($urandom);
    endtask

    task automatic send8(input bit sel, input logic [7:0] data, input logic last);
        logic rdy;
        d8 = data;
        k8 = 1'b1;
        l8 = last;
        if (sel) v_c16n = 1'b1;
        else     v_c8   = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 40 && !rdy; i++) begin
            @(negedge clk);
            rdy = sel ? sr_c16n : sr_c8;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL send8: s_ready stayed low for 40 cycles");
        end
        @(posedge clk);
        #1;
        v_c8   = 1'b0;
        v_c16n = 1'b0;
        d8     = 8'($urandom);
        l8     = 1'($urandom);
    endtask

    task automatic frame_123(input bit sel);
        send32(sel, 32'h3433_3231, 4'hF, 1'b0);
        send32(sel, 32'h3837_3635, 4'hF, 1'b0);
        send32(sel, 32'h0000_0039, 4'h1, 1'b1);
    endtask

    task automatic flush_all();
        sb_c32.delete();
        sb_c16w.delete();
        sb_c16n.delete();
        sb_c8.delete();
    endtask

    initial begin
        int t0;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        d32 = '0; k32 = '0; l32 = 1'b0; v_c32 = 1'b0; v_c16w = 1'b0;
        d8 = '0; k8 = '0; l8 = 1'b0; v_c8 = 1'b0; v_c16n = 1'b0;
        r_c32 = 1'b1; r_c16w = 1'b1; r_c8 = 1'b1; r_c16n = 1'b1;
        e32 = '0; e16w = '0; e8 = '0; e16n = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        check("reset m_valid", {31'h0, mv_c32}, 32'h0);
        check("reset m_crc", crc_c32, 32'h0);
        check("reset m_match/m_err", {30'h0, mt_c32, er_c32}, 32'h0);
        check("reset s_ready", {31'h0, sr_c32}, 32'h1);

        // CRC-8 single byte, result one cycle after the last beat
        e8 = 8'hEE;
        send8(1'b0, 8'h22, 1'b1);
        sb_c8.push_back(mk(32'hEE, 1'b1, 1'b0, 1'b1));
        check("crc8 latency m_valid", {31'h0, mv_c8}, 32'h1);
        e8 = 8'h00;
        send8(1'b0, 8'h22, 1'b1);
        sb_c8.push_back(mk(32'hEE, 1'b0, 1'b0, 1'b1));

        // CRC-16/CCITT-FALSE, byte-wide and word-wide
        e16n = 16'h29B1;
        for (int i = 0; i < 9; i++) send8(1'b1, 8'h31 + 8'(i), (i == 8));
        sb_c16n.push_back(mk(32'h29B1, 1'b1, 1'b0, 1'b1));
        e16w = 16'h29B1;
        frame_123(1'b1);
        sb_c16w.push_back(mk(32'h29B1, 1'b1, 1'b0, 1'b1));

        // CRC-32 check string, matching and non-matching expected value
        e32 = 32'hCBF4_3926;
        frame_123(1'b0);
        sb_c32.push_back(mk(32'hCBF4_3926, 1'b1, 1'b0, 1'b1));
        e32 = 32'h0;
        frame_123(1'b0);
        sb_c32.push_back(mk(32'hCBF4_3926, 1'b0, 1'b0, 1'b1));

        // Backpressure: result held, next frame (zero-byte) stalls until m_ready returns
        r_c32 = 1'b0;
        e32   = 32'h0;
        fork
            begin
                send32(1'b0, 32'h0, 4'h0, 1'b1);
                sb_c32.push_back(mk(32'h0, 1'b1, 1'b0, 1'b1));
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall s_ready low", {31'h0, sr_c32}, 32'h0);
                    check("stall m_crc held", crc_c32, 32'hCBF4_3926);
                    check("stall m_valid/m_match held", {30'h0, mv_c32, mt_c32}, 32'h2);
                end
                @(posedge clk);
                #1 r_c32 = 1'b1;
            end
        join
        check("replace keeps m_valid", {31'h0, mv_c32}, 32'h1);

        // Back-to-back frames "abc" and "a"
        e32 = 32'h3524_41C2;
        send32(1'b0, 32'h0063_6261, 4'h7, 1'b1);
        sb_c32.push_back(mk(32'h3524_41C2, 1'b1, 1'b0, 1'b1));
        t0 = cyc;
        e32 = 32'hE8B7_BE43;
        send32(1'b0, 32'h0000_0061, 4'h1, 1'b1);
        sb_c32.push_back(mk(32'hE8B7_BE43, 1'b1, 1'b0, 1'b1));
        check("back-to-back cycle gap", 32'(cyc - t0), 32'h1);
        check("back-to-back m_valid", {31'h0, mv_c32}, 32'h1);

        // Keep violations and recovery
        e32 = 32'h0;
        send32(1'b0, 32'h0063_0061, 4'h5, 1'b1);
        sb_c32.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0));
        e32 = 32'hE8B7_BE43;
        send32(1'b0, 32'h0061_0000, 4'h4, 1'b1);
        sb_c32.push_back(mk(32'hE8B7_BE43, 1'b1, 1'b1, 1'b1));
        e32 = 32'h3524_41C2;
        send32(1'b0, 32'h0063_6261, 4'h7, 1'b0);
        send32(1'b0, 32'h0, 4'h0, 1'b1);
        sb_c32.push_back(mk(32'h3524_41C2, 1'b1, 1'b1, 1'b1));
        send32(1'b0, 32'h0063_6261, 4'h7, 1'b1);
        sb_c32.push_back(mk(32'h3524_41C2, 1'b1, 1'b0, 1'b1));
        e32 = 32'h0;
        send32(1'b0, 32'h0, 4'h0, 1'b1);
        sb_c32.push_back(mk(32'h0, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        @(posedge clk);
        #1;

        // Reset while a result is held clears outputs without waiting for a clock edge
        r_c32 = 1'b0;
        e32   = 32'hE8B7_BE43;
        send32(1'b0, 32'h0000_0061, 4'h1, 1'b1);
        check("held before reset m_crc", crc_c32, 32'hE8B7_BE43);
        rst = 1'b1;
        #1;
        check("async reset m_valid", {31'h0, mv_c32}, 32'h0);
        check("async reset m_crc", crc_c32, 32'h0);
        check("async reset m_match", {31'h0, mt_c32}, 32'h0);
        flush_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 r_c32 = 1'b1;

        // Reset after first beat discards the partial CRC
        send32(1'b0, 32'h3433_3231, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        check("mid-frame reset m_valid", {31'h0, mv_c32}, 32'h0);
        flush_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        e32 = 32'hCBF4_3926;
        frame_123(1'b0);
        sb_c32.push_back(mk(32'hCBF4_3926, 1'b1, 1'b0, 1'b1));

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained",
              32'(sb_c32.size() + sb_c16w.size() + sb_c16n.size() + sb_c8.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
